dma_controller: RTL and testbench
=================================

DMA_CONTROLLER -- requirements
Module: dma_controller

Interface
REQ-001 SHALL have parameter WORD_SIZE, default 16, giving the data/address width.
REQ-002 SHALL have parameter NUM_CH, default 2, giving the number of independent DMA channels (1..8).
REQ-003 SHALL have parameter BURST_LEN, default 4, giving the maximum words per bus tenure.
REQ-004 SHALL have parameter LEN_W, default 12, giving the transfer-length counter width.
REQ-005 SHALL have: Clk  in  1  single clock; all logic on posedge Clk.
REQ-006 SHALL have: Reset  in  1  asynchronous, active-high reset.
REQ-007 SHALL have: cmd_valid  in  1; cmd_ready  out  1; cmd_ch  in  clog2(NUM_CH); cmd_addr  in  WORD_SIZE; cmd_len  in  LEN_W — CPU command port.
REQ-008 SHALL have: dev_valid  in  NUM_CH; dev_ready  out  NUM_CH; dev_data  in  NUM_CH*WORD_SIZE — per-channel device source; channel i uses slice i.
REQ-009 SHALL have: BR  out  1 bus request; BG  in  1 bus grant.
REQ-010 SHALL have: writeM  out  1; address  out  WORD_SIZE; data  out  WORD_SIZE; mem_ack  in  1 — memory write port.
REQ-011 SHALL have: busy  out  NUM_CH; done_irq  out  NUM_CH — per-channel status and one-cycle completion pulse.

Function
REQ-012 SHALL assert cmd_ready = !busy[cmd_ch]; a command is accepted on cmd_valid && cmd_ready; accepting it latches addr/len and sets busy[cmd_ch] next cycle.
REQ-013 SHALL treat an accepted command with cmd_len==0 as complete: done_irq[ch] pulses the next cycle; busy never set; no BR.
REQ-014 SHALL implement FSM IDLE -> REQ -> XFER -> REL -> (REQ | IDLE).
REQ-015 In IDLE with any busy channel, SHALL select one by round-robin starting after the last serviced channel, then go to REQ.
REQ-016 In REQ, SHALL hold BR=1 and enter XFER on the first cycle BG=1.
REQ-017 In XFER, SHALL move min(BURST_LEN, remaining) words of the selected channel, holding BR=1.
REQ-018 For each word, SHALL pop dev_data when dev_valid && dev_ready into a one-word holding register; dev_ready is high when the holding register is empty, or is being written this cycle, and words remain in the burst.
REQ-019 SHALL drive writeM=1 with address/data stable while the holding register is full, until mem_ack; on mem_ack, address increments by 1 (wrapping modulo 2^WORD_SIZE) and remaining decrements.
REQ-020 After the last word of a burst is acked, SHALL go to REL, drive BR=0, and leave REL once BG=0.
REQ-021 On leaving REL, SHALL re-arbitrate if any channel is busy (go to REQ), otherwise go to IDLE; a channel reaching remaining==0 clears busy and pulses done_irq in the same cycle as its final mem_ack.
REQ-022 If BG falls during XFER, SHALL drop writeM in the same cycle (combinational gate), keep BR=1 and the holding register, return to REQ, and resume the same burst count.
REQ-023 A new command for another channel SHALL be accepted in any state without disturbing the active transfer.
REQ-024 Outputs other than writeM/dev_ready/cmd_ready SHALL be registered.

Reset
REQ-025 Reset SHALL force: FSM=IDLE; BR=0; writeM=0; address=0; data=0; busy=0; done_irq=0; holding register empty; round-robin pointer=0.
REQ-026 Reset asserted mid-transfer SHALL abandon it with no done_irq pulse.

Structure
REQ-027 The FSM state encoding and default parameter values SHALL live in shared package dma_pkg, alongside const.v.
REQ-028 Round-robin selection SHALL be a separate sub-module dma_rr_arbiter (request vector in, one-hot grant out, pointer update on enable).

Verification
REQ-029 Ch0 cmd addr=0x0100 len=3, BG one cycle after BR, mem_ack every cycle -> writes 0x0100..0x0102 in order, BR drops after the third ack, done_irq[0] is a single pulse.
REQ-030 Ch0 len=10, BURST_LEN=4 -> three tenures of 4, 4 and 2 words, with BR low for at least one cycle between tenures while BG=0.
REQ-031 Ch0 and ch1 each len=8, issued the same cycle -> bursts alternate ch0, ch1, ch0, ch1; each done_irq fires once.
REQ-032 addr=0xFFFE len=4 -> addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001.
REQ-033 BG dropped after the 2nd word of a 4-word burst, then regranted -> writeM low while BG=0; the remaining 2 words are written with no loss or duplication.
REQ-034 len=0 command -> done_irq pulse next cycle, BR stays 0; Reset mid-burst -> all outputs at reset values and no done_irq.

Source files
------------

// File: rtl/dma_pkg.sv
// Shared definitions for the DMA controller: FSM state encoding, default
// parameter values and a width helper for channel indices.
package dma_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_XFER = 2'd2,
    ST_REL  = 2'd3
  } dma_state_e;

  localparam int DMA_WORD_SIZE = 16;
  localparam int DMA_NUM_CH    = 2;
  localparam int DMA_BURST_LEN = 4;
  localparam int DMA_LEN_W     = 12;

  // Index width that stays at least one bit for single-entry vectors.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dma_rr_arbiter.sv
// Round-robin arbiter: one-hot grant starting the search at the channel after
// the last one serviced; the pointer only advances when en is high.
module dma_rr_arbiter
  import dma_pkg::*;
#(
  parameter int N = DMA_NUM_CH
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic [N-1:0] req,
  input  logic         en,
  output logic [N-1:0] grant
);

  localparam int PW = idx_width(N);

  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] idx_sel;
  logic          found;
  int            idx;

  always_comb begin
    grant   = '0;
    found   = 1'b0;
    idx     = 0;
    idx_sel = '0;
    ptr_d   = ptr_q;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= N) idx = idx - N;
      idx_sel = PW'(idx);
      if (!found && req[idx_sel]) begin
        found          = 1'b1;
        grant[idx_sel] = 1'b1;
        if (en) ptr_d = (idx == N - 1) ? '0 : PW'(idx + 1);
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/dma_controller.sv
// Multi-channel DMA engine: per-channel commands are drained from device
// sources into memory in bus tenures of at most BURST_LEN words.
module dma_controller
  import dma_pkg::*;
#(
  parameter int WORD_SIZE = DMA_WORD_SIZE,
  parameter int NUM_CH    = DMA_NUM_CH,
  parameter int BURST_LEN = DMA_BURST_LEN,
  parameter int LEN_W     = DMA_LEN_W
) (
  input  logic                          Clk,
  input  logic                          Reset,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [idx_width(NUM_CH)-1:0]  cmd_ch,
  input  logic [WORD_SIZE-1:0]          cmd_addr,
  input  logic [LEN_W-1:0]              cmd_len,
  input  logic [NUM_CH-1:0]             dev_valid,
  output logic [NUM_CH-1:0]             dev_ready,
  input  logic [NUM_CH*WORD_SIZE-1:0]   dev_data,
  output logic                          BR,
  input  logic                          BG,
  output logic                          writeM,
  output logic [WORD_SIZE-1:0]          address,
  output logic [WORD_SIZE-1:0]          data,
  input  logic                          mem_ack,
  output logic [NUM_CH-1:0]             busy,
  output logic [NUM_CH-1:0]             done_irq
);

  localparam int CH_W = idx_width(NUM_CH);
  localparam int BL_W = $clog2(BURST_LEN + 1);

  dma_state_e           state_q, state_d;
  logic                 br_q, br_d;
  logic                 hold_q, hold_d;
  logic [WORD_SIZE-1:0] address_q, address_d;
  logic [WORD_SIZE-1:0] data_q, data_d;
  logic [CH_W-1:0]      sel_q, sel_d;
  logic [BL_W-1:0]      burst_q, burst_d;
  logic [NUM_CH-1:0]    busy_q, busy_d;
  logic [NUM_CH-1:0]    done_q, done_d;
  logic [WORD_SIZE-1:0] addr_q [NUM_CH];
  logic [WORD_SIZE-1:0] addr_d [NUM_CH];
  logic [LEN_W-1:0]     rem_q  [NUM_CH];
  logic [LEN_W-1:0]     rem_d  [NUM_CH];
  logic [WORD_SIZE-1:0] dev_word [NUM_CH];

  logic [NUM_CH-1:0] grant;
  logic [CH_W-1:0]   grant_idx;
  logic [LEN_W-1:0]  grant_rem;
  logic [BL_W-1:0]   first_burst;
  logic              arb_en;
  logic              ch_ok;
  logic              xfer_live;
  logic              ack;
  logic              pop_ok;
  logic              pop;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_dev_word
    assign dev_word[gi] = dev_data[gi*WORD_SIZE +: WORD_SIZE];
  end

  if (NUM_CH == (1 << CH_W)) begin : g_ch_full
    assign ch_ok = 1'b1;
  end else begin : g_ch_range
    assign ch_ok = (cmd_ch < CH_W'(NUM_CH));
  end

  dma_rr_arbiter #(.N(NUM_CH)) u_arb (
    .Clk   (Clk),
    .Reset (Reset),
    .req   (busy_q),
    .en    (arb_en),
    .grant (grant)
  );

  always_comb begin
    grant_idx = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (grant[c]) grant_idx = CH_W'(c);
    end
    grant_rem   = rem_q[grant_idx];
    first_burst = (int'(grant_rem) > BURST_LEN) ? BL_W'(BURST_LEN) : BL_W'(grant_rem);
  end

  // writeM and dev_ready are gated by BG combinationally so a revoked grant
  // stops bus activity in the same cycle; the holding word is kept.
  assign xfer_live = (state_q == ST_XFER) && BG;
  assign writeM    = xfer_live && hold_q;
  assign ack       = writeM && mem_ack;
  assign pop_ok    = xfer_live && (burst_q != BL_W'(hold_q)) && (!hold_q || ack);
  assign pop       = pop_ok && dev_valid[sel_q];
  assign dev_ready = pop_ok ? (NUM_CH'(1) << sel_q) : '0;
  assign cmd_ready = ch_ok && !busy_q[cmd_ch];

  assign BR       = br_q;
  assign address  = address_q;
  assign data     = data_q;
  assign busy     = busy_q;
  assign done_irq = done_q;

  always_comb begin
    state_d   = state_q;
    br_d      = br_q;
    hold_d    = hold_q;
    address_d = address_q;
    data_d    = data_q;
    sel_d     = sel_q;
    burst_d   = burst_q;
    busy_d    = busy_q;
    done_d    = '0;
    addr_d    = addr_q;
    rem_d     = rem_q;
    arb_en    = 1'b0;

    if (cmd_valid && cmd_ready) begin
      addr_d[cmd_ch] = cmd_addr;
      rem_d[cmd_ch]  = cmd_len;
      if (cmd_len == '0) done_d[cmd_ch] = 1'b1;
      else               busy_d[cmd_ch] = 1'b1;
    end

    // A word popped in the same cycle as an ack belongs to the next address.
    if (pop) begin
      hold_d    = 1'b1;
      data_d    = dev_word[sel_q];
      address_d = ack ? addr_q[sel_q] + WORD_SIZE'(1) : addr_q[sel_q];
    end

    if (ack) begin
      hold_d        = pop;
      addr_d[sel_q] = addr_q[sel_q] + WORD_SIZE'(1);
      rem_d[sel_q]  = rem_q[sel_q] - LEN_W'(1);
      burst_d       = burst_q - BL_W'(1);
      if (rem_q[sel_q] == LEN_W'(1)) begin
        busy_d[sel_q] = 1'b0;
        done_d[sel_q] = 1'b1;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (|busy_q) begin
          arb_en  = 1'b1;
          sel_d   = grant_idx;
          burst_d = first_burst;
          br_d    = 1'b1;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (BG) state_d = ST_XFER;
      end
      ST_XFER: begin
        if (!BG) begin
          state_d = ST_REQ;
        end else if (ack && burst_q == BL_W'(1)) begin
          br_d    = 1'b0;
          state_d = ST_REL;
        end
      end
      ST_REL: begin
        if (!BG) begin
          if (|busy_q) begin
            arb_en  = 1'b1;
            sel_d   = grant_idx;
            burst_d = first_burst;
            br_d    = 1'b1;
            state_d = ST_REQ;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= ST_IDLE;
      br_q      <= 1'b0;
      hold_q    <= 1'b0;
      address_q <= '0;
      data_q    <= '0;
      sel_q     <= '0;
      burst_q   <= '0;
      busy_q    <= '0;
      done_q    <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        addr_q[c] <= '0;
        rem_q[c]  <= '0;
      end
    end else begin
      state_q   <= state_d;
      br_q      <= br_d;
      hold_q    <= hold_d;
      address_q <= address_d;
      data_q    <= data_d;
      sel_q     <= sel_d;
      burst_q   <= burst_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      addr_q    <= addr_d;
      rem_q     <= rem_d;
    end
  end

endmodule

// File: tb/tb_dma_controller.sv
// Self-checking bench for dma_controller: bus/memory/device models plus a
// per-channel scoreboard of expected {address,data} memory writes.
module tb_dma_controller;

  localparam int WS  = 16;
  localparam int NCH = 2;
  localparam int BL  = 4;
  localparam int LW  = 12;

  logic              Clk = 1'b0;
  logic              Reset = 1'b1;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [0:0]        cmd_ch = '0;
  logic [WS-1:0]     cmd_addr = '0;
  logic [LW-1:0]     cmd_len = '0;
  logic [NCH-1:0]    dev_valid = '0;
  logic [NCH-1:0]    dev_ready;
  logic [NCH*WS-1:0] dev_data = '0;
  logic              BR;
  logic              BG = 1'b0;
  logic              writeM;
  logic [WS-1:0]     address;
  logic [WS-1:0]     data;
  logic              mem_ack = 1'b0;
  logic [NCH-1:0]    busy;
  logic [NCH-1:0]    done_irq;

  always #5 Clk = ~Clk;

  dma_controller #(.WORD_SIZE(WS), .NUM_CH(NCH), .BURST_LEN(BL), .LEN_W(LW)) dut (
    .Clk(Clk), .Reset(Reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ch(cmd_ch),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .dev_valid(dev_valid), .dev_ready(dev_ready), .dev_data(dev_data),
    .BR(BR), .BG(BG),
    .writeM(writeM), .address(address), .data(data), .mem_ack(mem_ack),
    .busy(busy), .done_irq(done_irq)
  );

  int n_checks = 0;
  int n_fail   = 0;

  int          dev_idx [NCH];
  int          exp_idx [NCH];
  int          done_cnt [NCH];
  logic [31:0] exp_q0 [$];
  logic [31:0] exp_q1 [$];
  int          pop_ch_q [$];
  int          ten_ch [$];
  int          ten_words [$];
  int          wr_cnt = 0;
  int          gate_seen = 0;
  int          burst_words = 0;
  int          cur_ch = 0;
  logic        br_prev = 1'b0;
  int          bg_low_cnt = 0;
  int          drop_at = -1;
  bit          ack_rand = 1'b0;
  bit          dv_rand = 1'b0;
  int          m_ch;
  logic [31:0] m_exp;
  bit          m_have;

  initial begin
    for (int c = 0; c < NCH; c++) begin
      dev_idx[c] = 0; exp_idx[c] = 0; done_cnt[c] = 0;
    end
  end

  // Bus, memory and device models drive at the falling edge, then the
  // monitor samples 1ns later what the next rising edge will consume.
  always @(negedge Clk) begin
    BG = (bg_low_cnt > 0) ? 1'b0 : BR;
    if (bg_low_cnt > 0) bg_low_cnt--;
    mem_ack = ack_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    for (int c = 0; c < NCH; c++) begin
      dev_valid[c] = dv_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      dev_data[c*WS +: WS] = {4'(c), 12'(dev_idx[c])};
    end
    #1;
    if (Reset) begin
      br_prev = 1'b0;
      burst_words = 0;
    end else begin
      if (BR && !BG) begin
        gate_seen++;
        n_checks++;
        if (writeM !== 1'b0) begin
          n_fail++;
          $display("FAIL writeM_gate: writeM=%b while BG=0, required 0", writeM);
        end
      end
      if (writeM && mem_ack) begin
        n_checks++;
        m_have = 1'b0;
        m_ch = -1;
        if (pop_ch_q.size() > 0) begin
          m_ch = pop_ch_q.pop_front();
          if (m_ch == 0 && exp_q0.size() > 0) begin m_exp = exp_q0.pop_front(); m_have = 1'b1; end
          if (m_ch == 1 && exp_q1.size() > 0) begin m_exp = exp_q1.pop_front(); m_have = 1'b1; end
        end
        if (!m_have) begin
          n_fail++;
          $display("FAIL scoreboard_extra: unexpected write addr=%h data=%h ch=%0d", address, data, m_ch);
        end else if ({address, data} !== m_exp) begin
          n_fail++;
          $display("FAIL scoreboard: ch%0d got addr=%h data=%h, required addr=%h data=%h",
                   m_ch, address, data, m_exp[31:16], m_exp[15:0]);
        end
        wr_cnt++;
        burst_words++;
        cur_ch = m_ch;
        if (wr_cnt == drop_at) bg_low_cnt = 4;
      end
      for (int c = 0; c < NCH; c++) begin
        if (dev_valid[c] && dev_ready[c]) begin
          pop_ch_q.push_back(c);
          dev_idx[c]++;
        end
        if (done_irq[c]) done_cnt[c]++;
      end
      if (br_prev && !BR) begin
        ten_ch.push_back(cur_ch);
        ten_words.push_back(burst_words);
        burst_words = 0;
      end
      br_prev = BR;
    end
  end

  task automatic issue_cmd(input int ch, input logic [WS-1:0] addr, input int len);
    int waited = 0;
    logic [WS-1:0] a;
    @(negedge Clk);
    cmd_ch = 1'(ch); cmd_addr = addr; cmd_len = LW'(len);
    #2;
    while (!cmd_ready && waited < 500) begin @(negedge Clk); #2; waited++; end
    if (!cmd_ready) begin
      n_checks++; n_fail++;
      $display("FAIL cmd_ready_timeout: ch%0d cmd_ready=%b, required 1", ch, cmd_ready);
      return;
    end
    cmd_valid = 1'b1;
    for (int k = 0; k < len; k++) begin
      a = addr + WS'(k);
      if (ch == 0) exp_q0.push_back({a, 4'(ch), 12'(exp_idx[ch] + k)});
      else         exp_q1.push_back({a, 4'(ch), 12'(exp_idx[ch] + k)});
    end
    exp_idx[ch] += len;
    @(negedge Clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int cyc = 0;
    do begin @(negedge Clk); #2; cyc++; end
    while (!(busy == '0 && !BR && exp_q0.size() == 0 && exp_q1.size() == 0) && cyc < budget);
    n_checks++;
    if (!(busy == '0 && !BR && exp_q0.size() == 0 && exp_q1.size() == 0)) begin
      n_fail++;
      $display("FAIL done_timeout: busy=%b BR=%b pending=%0d/%0d, required idle and empty",
               busy, BR, exp_q0.size(), exp_q1.size());
    end
    repeat (2) @(negedge Clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge Clk);
    #2;
    n_checks++; if (BR !== 1'b0) begin n_fail++; $display("FAIL reset_BR: got %b, required 0", BR); end
    n_checks++; if (writeM !== 1'b0) begin n_fail++; $display("FAIL reset_writeM: got %b, required 0", writeM); end
    n_checks++; if (address !== '0) begin n_fail++; $display("FAIL reset_address: got %h, required 0000", address); end
    n_checks++; if (data !== '0) begin n_fail++; $display("FAIL reset_data: got %h, required 0000", data); end
    n_checks++; if (busy !== '0) begin n_fail++; $display("FAIL reset_busy: got %b, required 00", busy); end
    n_checks++; if (done_irq !== '0) begin n_fail++; $display("FAIL reset_done_irq: got %b, required 00", done_irq); end
    n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cmd_ready: got %b, required 1", cmd_ready); end
    Reset = 1'b0;
    repeat (2) @(negedge Clk);
  endtask

  task automatic test_basic();
    int w0 = wr_cnt; int d0 = done_cnt[0];
    ten_ch.delete(); ten_words.delete();
    issue_cmd(0, 16'h0100, 3);
    wait_done(200);
    n_checks++; if (wr_cnt - w0 != 3) begin n_fail++; $display("FAIL basic_writes: got %0d, required 3", wr_cnt - w0); end
    n_checks++;
    if (ten_words.size() != 1 || ten_words[0] != 3) begin
      n_fail++; $display("FAIL basic_tenure: got %0d tenures (first %0d words), required 1 of 3",
                         ten_words.size(), (ten_words.size() > 0) ? ten_words[0] : -1);
    end
    n_checks++; if (done_cnt[0] - d0 != 1) begin n_fail++; $display("FAIL basic_done_pulse: got %0d cycles, required 1", done_cnt[0] - d0); end
  endtask

  task automatic test_multi_burst();
    int d0 = done_cnt[0];
    int req_words [3] = '{4, 4, 2};
    ten_ch.delete(); ten_words.delete();
    issue_cmd(0, 16'h2000, 10);
    wait_done(300);
    n_checks++;
    if (ten_words.size() != 3) begin
      n_fail++; $display("FAIL multi_tenures: got %0d, required 3", ten_words.size());
    end else begin
      for (int t = 0; t < 3; t++) begin
        n_checks++;
        if (ten_words[t] != req_words[t]) begin
          n_fail++; $display("FAIL multi_tenure_len[%0d]: got %0d, required %0d", t, ten_words[t], req_words[t]);
        end
      end
    end
    n_checks++; if (done_cnt[0] - d0 != 1) begin n_fail++; $display("FAIL multi_done: got %0d, required 1", done_cnt[0] - d0); end
  endtask

  task automatic test_two_channels();
    int d0 = done_cnt[0]; int d1 = done_cnt[1];
    ten_ch.delete(); ten_words.delete();
    issue_cmd(0, 16'h3000, 8);
    issue_cmd(1, 16'h4000, 8);
    wait_done(400);
    n_checks++;
    if (ten_ch.size() != 4) begin
      n_fail++; $display("FAIL rr_tenures: got %0d, required 4", ten_ch.size());
    end else begin
      for (int t = 0; t < 4; t++) begin
        n_checks++;
        if (ten_ch[t] != (t % 2) || ten_words[t] != 4) begin
          n_fail++; $display("FAIL rr_order[%0d]: got ch%0d/%0d words, required ch%0d/4 words",
                             t, ten_ch[t], ten_words[t], t % 2);
        end
      end
    end
    n_checks++; if (done_cnt[0] - d0 != 1) begin n_fail++; $display("FAIL rr_done0: got %0d, required 1", done_cnt[0] - d0); end
    n_checks++; if (done_cnt[1] - d1 != 1) begin n_fail++; $display("FAIL rr_done1: got %0d, required 1", done_cnt[1] - d1); end
  endtask

  task automatic test_wrap();
    int w0 = wr_cnt;
    issue_cmd(1, 16'hFFFE, 4);
    wait_done(200);
    n_checks++; if (wr_cnt - w0 != 4) begin n_fail++; $display("FAIL wrap_writes: got %0d, required 4", wr_cnt - w0); end
  endtask

  task automatic test_bg_drop();
    int w0 = wr_cnt; int g0 = gate_seen;
    ten_ch.delete(); ten_words.delete();
    drop_at = wr_cnt + 2;
    issue_cmd(0, 16'h5000, 4);
    wait_done(200);
    drop_at = -1;
    n_checks++; if (wr_cnt - w0 != 4) begin n_fail++; $display("FAIL bgdrop_writes: got %0d, required 4", wr_cnt - w0); end
    n_checks++; if (gate_seen - g0 < 3) begin n_fail++; $display("FAIL bgdrop_gap: BG low with BR high for %0d cycles, required >=3", gate_seen - g0); end
    n_checks++;
    if (ten_words.size() != 1 || ten_words[0] != 4) begin
      n_fail++; $display("FAIL bgdrop_tenure: got %0d tenures, required 1 of 4 words", ten_words.size());
    end
  endtask

  task automatic test_zero_len();
    int d1 = done_cnt[1];
    issue_cmd(1, 16'h6000, 0);
    #2;
    n_checks++; if (done_irq[1] !== 1'b1) begin n_fail++; $display("FAIL zero_done: got %b, required 1", done_irq[1]); end
    n_checks++; if (busy[1] !== 1'b0) begin n_fail++; $display("FAIL zero_busy: got %b, required 0", busy[1]); end
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk); #2;
      n_checks++;
      if (BR !== 1'b0 || done_irq[1] !== 1'b0) begin
        n_fail++; $display("FAIL zero_after[%0d]: BR=%b done_irq=%b, required 0/0", i, BR, done_irq[1]);
      end
    end
    n_checks++; if (done_cnt[1] - d1 != 1) begin n_fail++; $display("FAIL zero_pulse: got %0d, required 1", done_cnt[1] - d1); end
  endtask

  task automatic test_reset_mid();
    int w0 = wr_cnt; int cyc = 0; int d0;
    issue_cmd(0, 16'h7000, 8);
    while (wr_cnt < w0 + 2 && cyc < 300) begin @(negedge Clk); #2; cyc++; end
    n_checks++; if (wr_cnt < w0 + 2) begin n_fail++; $display("FAIL rstmid_start: got %0d writes, required 2", wr_cnt - w0); end
    @(negedge Clk);
    Reset = 1'b1;
    #2;
    n_checks++;
    if (BR !== 1'b0 || writeM !== 1'b0 || address !== '0 || data !== '0 || busy !== '0 || done_irq !== '0) begin
      n_fail++; $display("FAIL rstmid_outputs: BR=%b writeM=%b addr=%h data=%h busy=%b done=%b, required all 0",
                         BR, writeM, address, data, busy, done_irq);
    end
    exp_q0.delete(); exp_q1.delete(); pop_ch_q.delete();
    ten_ch.delete(); ten_words.delete();
    for (int c = 0; c < NCH; c++) exp_idx[c] = dev_idx[c];
    d0 = done_cnt[0];
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    repeat (10) @(negedge Clk);
    #2;
    n_checks++; if (done_cnt[0] != d0) begin n_fail++; $display("FAIL rstmid_no_done: got %0d pulses, required 0", done_cnt[0] - d0); end
    n_checks++; if (BR !== 1'b0 || busy !== '0) begin n_fail++; $display("FAIL rstmid_idle: BR=%b busy=%b, required 0/00", BR, busy); end
  endtask

  task automatic test_back_to_back();
    int w0 = wr_cnt; int d0 = done_cnt[0]; int d1 = done_cnt[1];
    ack_rand = 1'b1; dv_rand = 1'b1;
    issue_cmd(0, 16'h8000, 6);
    issue_cmd(1, 16'h9000, 5);
    wait_done(3000);
    ack_rand = 1'b0; dv_rand = 1'b0;
    n_checks++; if (wr_cnt - w0 != 11) begin n_fail++; $display("FAIL b2b_writes: got %0d, required 11", wr_cnt - w0); end
    n_checks++;
    if (done_cnt[0] - d0 != 1 || done_cnt[1] - d1 != 1) begin
      n_fail++; $display("FAIL b2b_done: got %0d/%0d, required 1/1", done_cnt[0] - d0, done_cnt[1] - d1);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_multi_burst();
    test_two_channels();
    test_wrap();
    test_bg_drop();
    test_zero_len();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
